// File: rtl/ps2_command_decoder_pkg.sv
`default_nettype none
// ============================================================================
// ps2_cmd_pkg : scancode constants, FSM state type and command lookup table
// Rev 1.0
// ============================================================================
package ps2_cmd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam int         LUT_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic                 hit;
        logic [LUT_IDX_W-1:0] idx;
    } cmd_lookup_t;

    typedef logic [LUT_IDX_W:0] lut_count_t;

    function automatic cmd_lookup_t cmd_lookup(input logic [7:0] code);
        cmd_lookup_t res;
        res.hit = 1'b1;
        res.idx = '0;
        case (code)
            8'h29:   res.idx = 4'd0;   // space : click
            8'h5A:   res.idx = 4'd1;   // enter : buy
            8'h16:   res.idx = 4'd2;
            8'h1E:   res.idx = 4'd3;
            8'h26:   res.idx = 4'd4;
            8'h25:   res.idx = 4'd5;
            8'h2E:   res.idx = 4'd6;
            8'h36:   res.idx = 4'd7;
            8'h3D:   res.idx = 4'd8;
            8'h3E:   res.idx = 4'd9;
            8'h21:   res.idx = 4'd10;  // C : upgradeClick
            default: res.hit = 1'b0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_cmd_slot.sv
`default_nettype none
// ============================================================================
// ps2_cmd_slot : one-entry valid/ready command register with sticky overflow
// Rev 1.0
// ============================================================================
module ps2_cmd_slot #(
    parameter int IDX_W = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             ready,
    input  logic             clr_overflow,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic             overflow
);

    logic accept;
    logic can_load;
    logic drop;

    assign accept   = valid && ready;
    assign can_load = !valid || ready;
    assign drop     = load && !can_load;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid <= 1'b0;
            idx   <= '0;
        end else if (load && can_load) begin
            valid <= 1'b1;
            idx   <= load_idx;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_command_decoder.sv
`default_nettype none
// ============================================================================
// ps2_command_decoder : PS/2 scancode to game command decoder with E0/F0
// prefix parsing, typematic repeat filter and valid/ready command output
// Rev 1.0
// ============================================================================
module ps2_command_decoder
    import ps2_cmd_pkg::*;
#(
    parameter int NUM_CMDS       = 11,
    parameter int IDX_W          = 4,
    parameter int REPEAT_FILTER  = 1,
    parameter int PREFIX_TIMEOUT = 65535
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    input  logic                cmd_ready,
    input  logic                clr_overflow,
    output logic                cmd_valid,
    output logic [IDX_W-1:0]    cmd_idx,
    output logic [NUM_CMDS-1:0] cmd_pulse,
    output logic                selection,
    output logic [NUM_CMDS-1:0] held_keys,
    output logic                overflow
);

    localparam int TMO_W = $clog2(PREFIX_TIMEOUT + 1);

    typedef logic [NUM_CMDS-1:0] cmd_vec_t;
    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [TMO_W-1:0]    tmo_t;

    localparam tmo_t       TMO_LAST     = tmo_t'(PREFIX_TIMEOUT - 1);
    localparam lut_count_t NUM_CMDS_LUT = lut_count_t'(NUM_CMDS);

    ps2_state_t  state;
    ps2_state_t  state_nxt;
    tmo_t        tmo_cnt;
    logic        timeout;
    cmd_lookup_t lk;
    logic        key_hit;
    logic        is_prefix;
    cmd_vec_t    key_mask;
    logic        sel_range;
    logic        make_ev;
    logic        break_ev;
    logic        emit;

    // Byte classification shared by the next-state and output logic
    assign lk        = cmd_lookup(received_data);
    assign key_hit   = lk.hit && ({1'b0, lk.idx} < NUM_CMDS_LUT);
    assign is_prefix = (received_data == SC_EXT) || (received_data == SC_BRK);
    assign key_mask  = key_hit ? (cmd_vec_t'(1) << lk.idx) : '0;
    assign sel_range = (lk.idx >= 4'd2) && (lk.idx <= 4'd9);
    assign timeout   = (state != ST_IDLE) && !received_data_en && (tmo_cnt == TMO_LAST);

    // ------------------------------------------------------------------
    // State register and prefix timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if ((state == ST_IDLE) || received_data_en || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + tmo_t'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (received_data_en) begin
            case (state)
                ST_IDLE: begin
                    if (received_data == SC_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (received_data == SC_BRK) begin
                        state_nxt = ST_BRK;
                    end
                end
                ST_EXT: begin
                    state_nxt = (received_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_BRK: begin
                    if (received_data == SC_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (received_data != SC_BRK) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (timeout) begin
            state_nxt = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output decode: make / break events and emit qualification
    // ------------------------------------------------------------------
    always_comb begin
        make_ev  = 1'b0;
        break_ev = 1'b0;
        emit     = 1'b0;
        if (received_data_en && key_hit && !is_prefix) begin
            make_ev  = (state == ST_IDLE);
            break_ev = (state == ST_BRK);
        end
        if (make_ev) begin
            emit = (REPEAT_FILTER == 0) || ((held_keys & key_mask) == '0);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            held_keys <= '0;
        end else if (make_ev) begin
            held_keys <= held_keys | key_mask;
        end else if (break_ev) begin
            held_keys <= held_keys & ~key_mask;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cmd_pulse <= '0;
            selection <= 1'b0;
        end else begin
            cmd_pulse <= emit ? key_mask : '0;
            selection <= emit && sel_range;
        end
    end

    ps2_cmd_slot #(
        .IDX_W (IDX_W)
    ) u_slot (
        .clock        (clock),
        .resetn       (resetn),
        .load         (emit),
        .load_idx     (idx_t'(lk.idx)),
        .ready        (cmd_ready),
        .clr_overflow (clr_overflow),
        .valid        (cmd_valid),
        .idx          (cmd_idx),
        .overflow     (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_decoder.sv
`default_nettype none
// ============================================================================
// tb_ps2_command_decoder : directed and random stimulus against a byte-level
// reference model of the decoder
// Rev 1.0
// ============================================================================
module tb_ps2_command_decoder;

    localparam int NC  = 11;
    localparam int TMO = 20;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    received_data = 8'h00;
    logic          received_data_en = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          cmd_valid;
    logic [3:0]    cmd_idx;
    logic [NC-1:0] cmd_pulse;
    logic          selection;
    logic [NC-1:0] held_keys;
    logic          overflow;

    ps2_command_decoder #(
        .NUM_CMDS       (NC),
        .IDX_W          (4),
        .REPEAT_FILTER  (1),
        .PREFIX_TIMEOUT (TMO)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .cmd_ready        (cmd_ready),
        .clr_overflow     (clr_overflow),
        .cmd_valid        (cmd_valid),
        .cmd_idx          (cmd_idx),
        .cmd_pulse        (cmd_pulse),
        .selection        (selection),
        .held_keys        (held_keys),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: prefix flags, idle-gap count, held set, command register
    bit          m_ext, m_brk;
    int          m_gap;
    bit [NC-1:0] m_held;
    bit          m_valid;
    int          m_idx;
    bit          m_ov;
    bit [NC-1:0] m_pulse;
    bit          m_sel;
    int          pulses_idx2;

    byte unsigned codes [NC] = '{8'h29, 8'h5A, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h21};
    byte unsigned junk  [4]  = '{8'h1C, 8'h15, 8'h76, 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < NC; i++) begin
            if (codes[i] == b) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_gap = 0; m_held = '0;
        m_valid = 0; m_idx = 0; m_ov = 0; m_pulse = '0; m_sel = 0;
    endtask

    task automatic model_update(input bit en, input logic [7:0] b, input bit rdy, input bit clr);
        int  k;
        bit  emit;
        bit  drop;
        k    = lookup(b);
        emit = 0;
        drop = 0;
        if (en) begin
            m_gap = 0;
            if (!m_ext && !m_brk) begin
                if (b == 8'hE0) m_ext = 1;
                else if (b == 8'hF0) m_brk = 1;
                else if (k >= 0) begin
                    emit = !m_held[k];
                    m_held[k] = 1;
                end
            end else if (m_ext && !m_brk) begin
                if (b == 8'hF0) m_brk = 1;
                else m_ext = 0;
            end else if (!m_ext && m_brk) begin
                if (b == 8'hE0) begin
                    m_ext = 1; m_brk = 0;
                end else if (b != 8'hF0) begin
                    if (k >= 0) m_held[k] = 0;
                    m_brk = 0;
                end
            end else begin
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_gap++;
            if (m_gap == TMO) begin
                m_ext = 0; m_brk = 0; m_gap = 0;
            end
        end
        if (emit) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                m_idx   = k;
            end else begin
                drop = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_ov    = drop ? 1'b1 : (clr ? 1'b0 : m_ov);
        m_pulse = emit ? (NC'(1) << k) : '0;
        m_sel   = emit && (k >= 2) && (k <= 9);
    endtask

    task automatic compare_all();
        check("valid", cmd_valid, m_valid);
        if (m_valid) check("idx", cmd_idx, m_idx);
        check("pulse", cmd_pulse, m_pulse);
        check("selection", selection, m_sel);
        check("held", held_keys, m_held);
        check("overflow", overflow, m_ov);
    endtask

    task automatic step(input bit en, input logic [7:0] b, input bit rdy, input bit clr);
        received_data_en = en;
        received_data    = b;
        cmd_ready        = rdy;
        clr_overflow     = clr;
        @(posedge clock);
        model_update(en, b, rdy, clr);
        #1;
        received_data_en = 1'b0;
        clr_overflow     = 1'b0;
        if (cmd_pulse[2]) pulses_idx2++;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0);
    endtask

    initial begin
        model_reset();
        pulses_idx2 = 0;
        #12;
        check("rst_valid", cmd_valid, 0);
        check("rst_pulse", cmd_pulse, 0);
        check("rst_held", held_keys, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clock);
        resetn = 1'b1;
        idle(2, 0);

        // 1: space -> idx 0, accepted next cycle
        step(1, 8'h29, 0, 0);
        check("t1_pulse", cmd_pulse, 11'h001);
        check("t1_idx", cmd_idx, 0);
        step(0, 8'h00, 1, 0);
        check("t1_drain", cmd_valid, 0);
        step(1, 8'hF0, 0, 0);
        step(1, 8'h29, 0, 0);

        // 2: typematic repeats of key 16 are filtered
        pulses_idx2 = 0;
        step(1, 8'h16, 1, 0);
        check("t2_sel", selection, 1);
        step(1, 8'h16, 1, 0);
        step(1, 8'h16, 1, 0);
        check("t2_held_rep", held_keys[2], 1);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h16, 1, 0);
        check("t2_held_brk", held_keys[2], 0);
        step(1, 8'h16, 1, 0);
        check("t2_held_again", held_keys[2], 1);
        idle(1, 1);
        check("t2_emits", pulses_idx2, 2);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h16, 1, 0);

        // 3: extended make/break are ignored, plain enter emits
        step(1, 8'hE0, 1, 0);
        step(1, 8'h5A, 1, 0);
        step(1, 8'hE0, 1, 0);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h5A, 1, 0);
        check("t3_noemit", cmd_pulse, 0);
        step(1, 8'h5A, 0, 0);
        check("t3_idx", cmd_idx, 1);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h5A, 1, 0);

        // 4: overflow while stalled, then accept-and-load in one cycle
        step(1, 8'h29, 0, 0);
        step(1, 8'h21, 0, 0);
        check("t4_keep_idx", cmd_idx, 0);
        check("t4_ovf", overflow, 1);
        check("t4_pulse10", cmd_pulse, 11'h400);
        step(0, 8'h00, 0, 1);
        check("t4_clr", overflow, 0);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h29, 1, 0);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h21, 1, 0);
        step(1, 8'h29, 0, 0);
        step(1, 8'h21, 1, 0);
        check("t4_load_idx", cmd_idx, 10);
        check("t4_no_ovf", overflow, 0);
        // drop and clear in the same cycle: drop wins
        step(1, 8'hF0, 0, 0);
        step(1, 8'h21, 0, 0);
        step(1, 8'h21, 0, 1);
        check("t4_set_wins", overflow, 1);
        step(0, 8'h00, 1, 1);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h21, 1, 0);
        step(1, 8'hF0, 1, 0);
        step(1, 8'h29, 1, 0);

        // 5: prefix timeout turns the next byte back into a make
        step(1, 8'hF0, 1, 0);
        idle(TMO, 1);
        step(1, 8'h3E, 1, 0);
        check("t5_emit9", cmd_pulse, 11'h200);
        step(1, 8'hF0, 1, 0);
        idle(TMO - 1, 1);
        step(1, 8'h3E, 1, 0);
        check("t5_break9", held_keys[9], 0);
        check("t5_no_emit", cmd_pulse, 0);

        // 6: asynchronous reset mid-prefix with a pending command
        step(1, 8'h29, 0, 0);
        step(1, 8'hF0, 0, 0);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("t6_valid", cmd_valid, 0);
        check("t6_held", held_keys, 0);
        check("t6_ovf", overflow, 0);
        @(negedge clock);
        resetn = 1'b1;
        step(1, 8'h26, 0, 0);
        check("t6_idx4", cmd_idx, 4);
        check("t6_pulse4", cmd_pulse, 11'h010);

        // Random byte stream with random gaps, ready and clear
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [7:0]  b;
            r = $urandom_range(0, 9);
            if (r == 0)      b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = junk[$urandom_range(0, 3)];
            else             b = codes[$urandom_range(0, NC - 1)];
            if ($urandom_range(0, 60) == 0) idle($urandom_range(TMO - 2, TMO + 1), $urandom_range(0, 1) == 1);
            step($urandom_range(0, 2) != 0, b, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
